// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: feedback mode, standard primitive tap masks and a
// width-generic next-state function usable by RTL, benches and checkers.
package lfsr_pkg;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

  // Bit i set means coefficient of x^(i+1).
  localparam logic [63:0] TAPS_4  = 64'h0000_0000_0000_000C;
  localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  // State and taps are carried zero-extended to 64 bits; width masks them.
  function automatic logic [63:0] lfsr_next(
    input logic [63:0] state,
    input logic [63:0] taps,
    input int unsigned width,
    input lfsr_mode_e  mode
  );
    logic [63:0] mask;
    logic [63:0] res;
    logic        fb;
    logic        msb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (mode == FIBONACCI) begin
      fb  = ^(state & taps & mask);
      res = ((state << 1) | {63'd0, fb}) & mask;
    end else begin
      msb = |(state & (64'd1 << (width - 1)));
      res = ((state << 1) ^ (msb ? ((taps << 1) | 64'd1) : '0)) & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr_step_cnt.sv
// Saturating step counter: clear has priority, increment stops at all ones.
module lfsr_step_cnt
  import lfsr_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lfsr_prbs.sv
// Parametrised PRBS / timeout LFSR with load, lock-up recovery, terminal
// reload and saturating step counter. Define LFSR_PRBS_GALOIS_EN for Galois form.
module lfsr_prbs
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 64,
  parameter logic [63:0]      TAPS  = 64'hD800_0000_0000_0000,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter int unsigned      CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             term_en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic             lfsr_to,
  output logic             lockup,
  output logic [CNT_W-1:0] step_cnt
);

`ifdef LFSR_PRBS_GALOIS_EN
  localparam lfsr_mode_e MODE = GALOIS;
`else
  localparam lfsr_mode_e MODE = FIBONACCI;
`endif

  logic [WIDTH-1:0] r_q;
  logic             r_lockup;
  logic [WIDTH-1:0] w_next;
  logic             w_zero;
  logic             w_term;
  logic             w_clr;
  logic             w_inc;

  assign w_next = WIDTH'(lfsr_next(64'(r_q), TAPS, WIDTH, MODE));
  assign w_zero = (r_q == '0);
  assign w_term = term_en && (r_q == term_val);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_q      <= SEED;
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      if (load) begin
        r_q <= load_val;
      end else if (w_zero) begin
        r_q      <= SEED;
        r_lockup <= 1'b1;
      end else if (en && w_term) begin
        r_q <= SEED;
      end else if (en) begin
        r_q <= w_next;
      end
    end
  end

  // Counter clears on every action that restarts the sequence; counts only real steps.
  assign w_clr = load || w_zero || (en && w_term);
  assign w_inc = en && !w_clr;

  lfsr_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clock  (clock),
    .reset_ (reset_),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_cnt  (step_cnt)
  );

  assign q       = r_q;
  assign lfsr_to = w_term;
  assign lockup  = r_lockup;

endmodule

// File: tb/tb_lfsr_prbs.sv
// Directed self-checking bench for lfsr_prbs (WIDTH=4, TAPS=x^4+x^3+1);
// expectations follow LFSR_PRBS_GALOIS_EN when it is defined.
module tb_lfsr_prbs;

  logic       clock;
  logic       reset_;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       term_en;
  logic [3:0] term_val;
  logic [3:0] q;
  logic       lfsr_to;
  logic       lockup;
  logic [7:0] step_cnt;
  logic [3:0] q_s;
  logic       lfsr_to_s;
  logic       lockup_s;
  logic [2:0] step_cnt_s;

  int unsigned n_chk;
  int unsigned n_fail;

  logic [3:0] exp_seq [4];
  logic [3:0] exp_first;
  logic [3:0] term_pre;

  lfsr_prbs #(
    .WIDTH (4),
    .TAPS  (64'h0000_0000_0000_000C),
    .SEED  (4'b1111),
    .CNT_W (8)
  ) dut (
    .clock    (clock),
    .reset_   (reset_),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .term_en  (term_en),
    .term_val (term_val),
    .q        (q),
    .lfsr_to  (lfsr_to),
    .lockup   (lockup),
    .step_cnt (step_cnt)
  );

  lfsr_prbs #(
    .WIDTH (4),
    .TAPS  (64'h0000_0000_0000_000C),
    .SEED  (4'b1111),
    .CNT_W (3)
  ) dut_s (
    .clock    (clock),
    .reset_   (reset_),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .term_en  (term_en),
    .term_val (term_val),
    .q        (q_s),
    .lfsr_to  (lfsr_to_s),
    .lockup   (lockup_s),
    .step_cnt (step_cnt_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
`ifdef LFSR_PRBS_GALOIS_EN
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b1001;
    exp_first  = 4'b0111;
    term_pre   = 4'b1000;
`else
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1001; exp_seq[3] = 4'b0011;
    exp_first  = 4'b1110;
    term_pre   = 4'b0100;
`endif
    reset_   = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'b0000;
    term_en  = 1'b1;
    term_val = 4'b1111;
    #12;
    chk("rst_q", q, 4'b1111);
    chk("rst_cnt", step_cnt, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_to_seed", lfsr_to, 1);
    term_en = 1'b0;
    #1;
    chk("rst_to_off", lfsr_to, 0);

    // First step after release
    @(negedge clock);
    reset_ = 1'b1;
    en     = 1'b1;
    tick();
    chk("first_step_q", q, exp_first);
    chk("first_step_cnt", step_cnt, 1);

    // Sequence and period from 0001
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'b0001;
    tick();
    chk("load_q", q, 4'b0001);
    chk("load_cnt", step_cnt, 0);
    load = 1'b0;
    en   = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i <= 4) chk($sformatf("seq%0d", i), q, exp_seq[i-1]);
      if (i == 6) chk("sat_cnt6", step_cnt_s, 6);
      if (i == 9) chk("sat_cnt9", step_cnt_s, 7);
    end
    chk("period_q", q, 4'b0001);
    chk("period_cnt", step_cnt, 15);
    chk("sat_cnt15", step_cnt_s, 7);

    // Hold with en low
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_q", q, 4'b0001);
    chk("hold_cnt", step_cnt, 15);

    // load beats en
    load     = 1'b1;
    en       = 1'b1;
    load_val = 4'b1010;
    tick();
    chk("load_en_q", q, 4'b1010);
    chk("load_en_cnt", step_cnt, 0);
    chk("load_en_sat_clr", step_cnt_s, 0);

    // Async reset after 7 steps
    load_val = 4'b0001;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_cnt", step_cnt, 7);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_rst_q", q, 4'b1111);
    chk("async_rst_cnt", step_cnt, 0);
    en = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;

    // Terminal reload
    term_en  = 1'b1;
    term_val = 4'b1001;
    load     = 1'b1;
    load_val = term_pre;
    tick();
    load = 1'b0;
    chk("term_pre_to", lfsr_to, 0);
    en = 1'b1;
    tick();
    chk("term_hit_q", q, 4'b1001);
    chk("term_hit_to", lfsr_to, 1);
    chk("term_hit_cnt", step_cnt, 1);
    en = 1'b0;
    tick();
    chk("term_noen_q", q, 4'b1001);
    chk("term_noen_to", lfsr_to, 1);
    en = 1'b1;
    tick();
    chk("term_reload_q", q, 4'b1111);
    chk("term_reload_cnt", step_cnt, 0);
    chk("term_reload_to", lfsr_to, 0);

    // Lock-up recovery
    en       = 1'b0;
    term_en  = 1'b0;
    load     = 1'b1;
    load_val = 4'b0000;
    tick();
    chk("zero_q", q, 0);
    chk("zero_lockup", lockup, 0);
    load = 1'b0;
    tick();
    chk("lock_q", q, 4'b1111);
    chk("lock_pulse", lockup, 1);
    chk("lock_cnt", step_cnt, 0);
    tick();
    chk("lock_end", lockup, 0);
    chk("lock_hold_q", q, 4'b1111);

    // load on the recovery edge wins
    load     = 1'b1;
    load_val = 4'b0000;
    tick();
    load_val = 4'b0110;
    tick();
    chk("lock_load_q", q, 4'b0110);
    chk("lock_load_pulse", lockup, 0);
    load = 1'b0;
    tick();
    chk("lock_load_after", lockup, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
